// File: rtl/pixel_cfg_pkg.sv
// Shared constants and state type for the pixel configuration write path.
package pixel_cfg_pkg;

  localparam int NUM_PIXELS = 180;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 15;
  localparam int CNT_W      = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int GAP_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pixel_cfg_fifo.sv
// Small synchronous FIFO buffering config words ahead of the sequencer.
// Pushes while full and pops while empty are ignored.
module pixel_cfg_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy tracking; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pixel_cfg_sequencer.sv
// Turns burst commands plus buffered config words into the per-pixel
// cfg_addr/cfg_data/cfg_valid write stream for the pixel config decoder.
//
//   state | meaning
//   IDLE  | waiting for a burst command, cmd_ready high
//   FETCH | waiting for a word, then issuing (or suppressing) one write
//   GAP   | settle time between consecutive writes
//   DONE  | burst complete, raises done on the way back to IDLE
module pixel_cfg_sequencer
  import pixel_cfg_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic              cmd_bcast,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [DATA_W-1:0] cfg_data,
  output logic              cfg_valid,
  output logic              busy,
  output logic              done,
  output logic              err_range
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  seq_state_t                  state;
  logic [ADDR_W-1:0]           cur_addr;
  logic [CNT_W-1:0]            remaining;
  logic                        bcast;
  logic                        bcast_held;
  logic [DATA_W-1:0]           bcast_word;
  logic [GAP_W-1:0]            gap_cnt;

  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        fifo_pop;
  logic [DATA_W-1:0]           fifo_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_level_unused;

  logic                        word_avail;
  logic [DATA_W-1:0]           word;
  logic                        in_range;

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign wr_ready   = ~fifo_full;

  // A broadcast burst reads the FIFO once and reuses the held copy afterwards.
  assign word_avail = ~fifo_empty | (bcast & bcast_held);
  assign fifo_pop   = (state == FETCH) & ~fifo_empty & ~(bcast & bcast_held);
  assign word       = (bcast & bcast_held) ? bcast_word : fifo_data;
  assign in_range   = (32'(cur_addr) < NUM_PIXELS);

  pixel_cfg_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_level_unused)
  );

  // Burst sequencing with registered write strobe, done pulse and sticky range error.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cur_addr   <= '0;
      remaining  <= '0;
      bcast      <= 1'b0;
      bcast_held <= 1'b0;
      bcast_word <= '0;
      gap_cnt    <= '0;
      cfg_addr   <= '0;
      cfg_data   <= '0;
      cfg_valid  <= 1'b0;
      done       <= 1'b0;
      err_range  <= 1'b0;
    end else begin
      cfg_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cur_addr   <= cmd_base;
            remaining  <= cmd_count;
            bcast      <= cmd_bcast;
            bcast_held <= 1'b0;
            err_range  <= 1'b0;
            state      <= (cmd_count == '0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          if (word_avail) begin
            if (bcast && !bcast_held) begin
              bcast_held <= 1'b1;
              bcast_word <= fifo_data;
            end
            if (in_range) begin
              cfg_addr  <= cur_addr;
              cfg_data  <= word;
              cfg_valid <= 1'b1;
            end else begin
              err_range <= 1'b1;
            end
            cur_addr  <= cur_addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              state <= DONE;
            end else if (GAP_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            end else begin
              state <= FETCH;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= FETCH;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_cfg_sequencer.sv
// Bench for pixel_cfg_sequencer: directed bursts plus randomized bursts,
// checked against a queue-based model of the FIFO and the burst address rules.
module tb_pixel_cfg_sequencer;
  import pixel_cfg_pkg::*;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base = '0;
  logic [CNT_W-1:0]  cmd_count = '0;
  logic              cmd_bcast = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              busy;
  logic              done;
  logic              err_range;

  pixel_cfg_sequencer dut (
    .clock     (clock),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_base  (cmd_base),
    .cmd_count (cmd_count),
    .cmd_bcast (cmd_bcast),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .busy      (busy),
    .done      (done),
    .err_range (err_range)
  );

  always #5 clock = ~clock;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  done_base = 0;
  int  acc_cyc = 0;
  wr_t obs_q[$];
  int  model_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  // Observed write stream and done pulses, sampled mid-cycle.
  always @(negedge clock) begin
    if (resetn && cfg_valid) obs_q.push_back('{int'(cfg_addr), int'(cfg_data), cyc});
    if (resetn && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check_val(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Holds wr_valid until the word is taken; called and returns on a negedge.
  task automatic push_word(input int d, output int refused);
    refused  = 0;
    wr_data  = DATA_W'(d);
    wr_valid = 1'b1;
    while (!wr_ready && refused < 60) begin
      @(negedge clock);
      refused++;
    end
    if (wr_ready) model_q.push_back(d);
    else check_val("push_timeout", 0, 1);
    @(negedge clock);
    wr_valid = 1'b0;
  endtask

  task automatic feed(input int n);
    int r;
    for (int i = 0; i < n; i++) push_word($urandom_range(0, 32767), r);
  endtask

  task automatic start_burst(input int base, input int count, input bit bc);
    int n;
    obs_q.delete();
    done_base = done_cnt;
    @(negedge clock);
    cmd_base  = ADDR_W'(base);
    cmd_count = CNT_W'(count);
    cmd_bcast = bc;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_val("cmd_ready_at_issue", cmd_ready, 1);
    @(negedge clock);
    cmd_valid = 1'b0;
    acc_cyc = cyc;
    check_val("err_cleared_on_accept", err_range, 0);
    check_val("busy_after_accept", busy, 1);
  endtask

  task automatic finish_burst(input int base, input int count, input bit bc, input bit exact_gap);
    int n;
    int exp_a[$];
    int exp_d[$];
    int w;
    int a;
    int m;
    bit exp_err;
    n = 0;
    while (done_cnt == done_base && n < count * 8 + 100) begin
      @(posedge clock);
      n++;
    end
    check_val("done_seen", done_cnt - done_base, 1);
    @(negedge clock);
    check_val("done_one_cycle", done, 0);
    check_val("busy_after_done", busy, 0);
    check_val("cmd_ready_after_done", cmd_ready, 1);
    exp_err = 1'b0;
    w = 0;
    for (int i = 0; i < count; i++) begin
      a = (base + i) % 256;
      if (!bc || i == 0) begin
        if (model_q.size() > 0) w = model_q.pop_front();
        else w = -1;
      end
      if (a < NUM_PIXELS) begin
        exp_a.push_back(a);
        exp_d.push_back(w);
      end else begin
        exp_err = 1'b1;
      end
    end
    check_val("err_range", err_range, int'(exp_err));
    check_val("n_writes", obs_q.size(), exp_a.size());
    m = (obs_q.size() < exp_a.size()) ? obs_q.size() : exp_a.size();
    for (int i = 0; i < m; i++) begin
      check_val($sformatf("addr[%0d]", i), obs_q[i].addr, exp_a[i]);
      check_val($sformatf("data[%0d]", i), obs_q[i].data, exp_d[i]);
      if (i > 0) begin
        if (exact_gap)
          check_val($sformatf("spacing[%0d]", i), obs_q[i].cyc - obs_q[i-1].cyc, GAP_CYCLES + 1);
        else
          check_val($sformatf("spacing_min[%0d]", i),
                    int'(obs_q[i].cyc - obs_q[i-1].cyc >= GAP_CYCLES + 1), 1);
      end
    end
    if (count == 0)
      check_val("done_latency_zero", done_cyc - acc_cyc, 1);
    else if (((base + count - 1) % 256) < NUM_PIXELS && obs_q.size() > 0)
      check_val("done_after_last", done_cyc - obs_q[obs_q.size()-1].cyc, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int base;
    int count;
    bit bc;
    int need;
    int pre;
    int space;
    int dsnap;

    repeat (3) @(negedge clock);
    check_val("rst_cfg_valid", cfg_valid, 0);
    check_val("rst_done", done, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_err", err_range, 0);
    check_val("rst_cmd_ready", cmd_ready, 1);
    check_val("rst_wr_ready", wr_ready, 1);
    resetn = 1'b1;
    @(negedge clock);

    // Addressed burst, with a stray command while busy that must be ignored.
    push_word('h11, r);
    push_word('h22, r);
    push_word('h33, r);
    start_burst(5, 3, 1'b0);
    @(negedge clock);
    cmd_base  = 8'd100;
    cmd_count = 8'd1;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    finish_burst(5, 3, 1'b0, 1'b1);

    // Broadcast over the whole array; the trailing word must survive for the next burst.
    push_word('h1234, r);
    push_word('h0777, r);
    start_burst(0, 180, 1'b1);
    finish_burst(0, 180, 1'b1, 1'b1);
    start_burst(10, 1, 1'b0);
    finish_burst(10, 1, 1'b0, 1'b1);

    // Range end and wrap region.
    feed(4);
    start_burst(178, 4, 1'b0);
    finish_burst(178, 4, 1'b0, 1'b1);
    start_burst(0, 0, 1'b0);
    finish_burst(0, 0, 1'b0, 1'b1);

    // Stall on empty FIFO, then resume.
    feed(1);
    start_burst(20, 2, 1'b0);
    repeat (12) @(negedge clock);
    check_val("stall_writes", obs_q.size(), 1);
    check_val("stall_busy", busy, 1);
    check_val("stall_cfg_valid", cfg_valid, 0);
    feed(1);
    finish_burst(20, 2, 1'b0, 1'b0);

    // Full FIFO, push refused on the pop cycle and accepted just after.
    feed(3);
    check_val("wr_ready_3_words", wr_ready, 1);
    feed(1);
    check_val("wr_ready_full", wr_ready, 0);
    start_burst(30, 5, 1'b0);
    push_word('h5a5a, r);
    check_val("refused_while_full", r, 1);
    finish_burst(30, 5, 1'b0, 1'b1);

    // Reset in the middle of a burst that has already hit an out-of-range address.
    feed(4);
    start_burst(179, 4, 1'b0);
    repeat (7) @(negedge clock);
    check_val("err_before_reset", err_range, 1);
    dsnap = done_cnt;
    #2 resetn = 1'b0;
    #1;
    check_val("mid_rst_cfg_valid", cfg_valid, 0);
    check_val("mid_rst_done", done, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_err", err_range, 0);
    check_val("mid_rst_cmd_ready", cmd_ready, 1);
    check_val("mid_rst_wr_ready", wr_ready, 1);
    @(negedge clock);
    resetn = 1'b1;
    model_q.delete();
    repeat (6) @(negedge clock);
    check_val("no_done_after_reset", done_cnt - dsnap, 0);
    feed(3);
    check_val("post_rst_3_words", wr_ready, 1);
    feed(1);
    check_val("post_rst_full", wr_ready, 0);
    start_burst(60, 4, 1'b0);
    finish_burst(60, 4, 1'b0, 1'b1);

    // Randomized bursts with concurrent feeding.
    for (int k = 0; k < 25; k++) begin
      base  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 255) : $urandom_range(170, 189);
      count = $urandom_range(0, 9);
      bc    = ($urandom_range(0, 3) == 0);
      space = FIFO_DEPTH - model_q.size();
      if (space > 0 && $urandom_range(0, 1) == 1) begin
        feed(1);
        space--;
      end
      need = bc ? ((count > 0) ? 1 : 0) : count;
      pre  = need - model_q.size();
      if (pre < 0) pre = 0;
      if (pre <= space) begin
        feed(pre);
        pre = 0;
      end else begin
        feed(space);
        pre = pre - space;
      end
      fork
        feed(pre);
        begin
          start_burst(base, count, bc);
          finish_burst(base, count, bc, 1'b0);
        end
      join
    end

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
